// File: rtl/motor_cmd_sequencer_pkg.sv
// Shared types and constants for the motor command sequencer.
// Holds the FSM state encoding, the speed codes and the one-code speed step helper.
package motor_pkg;

   typedef enum logic [2:0] {
      ST_HOLD      = 3'd0,
      ST_RAMP_UP   = 3'd1,
      ST_RAMP_DOWN = 3'd2,
      ST_BRAKE     = 3'd3,
      ST_ESTOP     = 3'd4
   } state_t;

   localparam logic [1:0] SPD_OFF = 2'b00;
   localparam logic [1:0] SPD_25  = 2'b01;
   localparam logic [1:0] SPD_50  = 2'b10;
   localparam logic [1:0] SPD_75  = 2'b11;

   localparam int PSW_DIR_BIT = 2;

   // One code toward the requested end, clamped so the 2-bit code never wraps.
   function automatic logic [1:0] step_speed(input logic [1:0] cur, input logic up);
      if (up) return (cur == SPD_75) ? SPD_75 : cur + 2'd1;
      else    return (cur == SPD_OFF) ? SPD_OFF : cur - 2'd1;
   endfunction

endpackage

// File: rtl/motor_cmd_sequencer_if.sv
// Speed/direction request handshake between a command source and the sequencer.
interface motor_cmd_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_speed;
   logic       cmd_dir;

   modport master (output cmd_valid, cmd_speed, cmd_dir, input cmd_ready);
   modport slave  (input cmd_valid, cmd_speed, cmd_dir, output cmd_ready);
endinterface

// File: rtl/motor_cmd_sequencer_tick_prescaler.sv
// Free-running timebase: one-cycle tick every TICK_DIV clocks, restartable by clr.
module tick_prescaler #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam int W = $clog2(TICK_DIV);

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          cnt <= '0;
      else if (clr || tick) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/motor_cmd_sequencer.sv
// Ramps the dc_motor psw word toward requested speed/direction one code per dwell,
// braking at OFF before any reversal, with an emergency-stop override.
module motor_cmd_sequencer
   import motor_pkg::*;
#(
   parameter int TICK_DIV    = 50000,
   parameter int STEP_TICKS  = 100,
   parameter int BRAKE_TICKS = 200
) (
   input  logic                 clk,
   input  logic                 rst_n,
   motor_cmd_sequencer_if.slave cmd,
   input  logic                 estop,
   output logic [2:0]           psw,
   output logic                 busy,
   output logic [2:0]           state_o
);
   localparam int MAX_TICKS = (STEP_TICKS > BRAKE_TICKS) ? STEP_TICKS : BRAKE_TICKS;
   localparam int DW        = $clog2(MAX_TICKS + 1);
   localparam logic [DW-1:0] STEP_LAST  = DW'(STEP_TICKS - 1);
   localparam logic [DW-1:0] BRAKE_LAST = DW'(BRAKE_TICKS - 1);

   state_t        state;
   logic          cur_dir, tgt_dir, rev;
   logic [1:0]    cur_speed, tgt_speed, ramp_tgt, next_speed;
   logic [DW-1:0] dwell;
   logic          tick, accept, ramping, step_due, brake_due, clr;

   assign cmd.cmd_ready = (state == ST_HOLD) && !estop;
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;
   assign ramping       = (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);
   assign step_due      = ramping && tick && (dwell == STEP_LAST);
   assign brake_due     = (state == ST_BRAKE) && tick && (dwell == BRAKE_LAST);
   // A pending reversal ramps to OFF first; the latched target speed applies after the brake.
   assign ramp_tgt      = rev ? SPD_OFF : tgt_speed;
   assign next_speed    = step_speed(cur_speed, state == ST_RAMP_UP);
   // Restart the timebase so each dwell is measured from its own entry edge.
   assign clr = accept || (!estop && ((step_due && rev && next_speed == ramp_tgt) || brake_due));

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_HOLD;
         cur_dir   <= 1'b0;
         cur_speed <= SPD_OFF;
         tgt_dir   <= 1'b0;
         tgt_speed <= SPD_OFF;
         rev       <= 1'b0;
         dwell     <= '0;
      end else if (estop) begin
         state     <= ST_ESTOP;
         cur_speed <= SPD_OFF;
         tgt_speed <= SPD_OFF;
         rev       <= 1'b0;
      end else begin
         case (state)
            ST_HOLD: if (accept) begin
               tgt_dir   <= cmd.cmd_dir;
               tgt_speed <= cmd.cmd_speed;
               dwell     <= '0;
               if (cmd.cmd_dir == cur_dir) begin
                  if (cmd.cmd_speed > cur_speed)      state <= ST_RAMP_UP;
                  else if (cmd.cmd_speed < cur_speed) state <= ST_RAMP_DOWN;
               end else if (cur_speed == SPD_OFF) begin
                  cur_dir <= cmd.cmd_dir;
                  if (cmd.cmd_speed != SPD_OFF) state <= ST_RAMP_UP;
               end else begin
                  rev   <= 1'b1;
                  state <= ST_RAMP_DOWN;
               end
            end
            ST_RAMP_UP, ST_RAMP_DOWN: if (tick) begin
               if (dwell == STEP_LAST) begin
                  dwell     <= '0;
                  cur_speed <= next_speed;
                  if (next_speed == ramp_tgt) state <= rev ? ST_BRAKE : ST_HOLD;
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            ST_BRAKE: if (tick) begin
               if (dwell == BRAKE_LAST) begin
                  dwell   <= '0;
                  cur_dir <= tgt_dir;
                  rev     <= 1'b0;
                  state   <= (tgt_speed != SPD_OFF) ? ST_RAMP_UP : ST_HOLD;
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            ST_ESTOP: begin
               state     <= ST_HOLD;
               tgt_dir   <= cur_dir;
               tgt_speed <= SPD_OFF;
            end
            default: state <= ST_HOLD;
         endcase
      end
   end

   assign psw[PSW_DIR_BIT] = cur_dir;
   assign psw[1:0]         = cur_speed;
   assign busy             = (state != ST_HOLD);
   assign state_o          = state;
endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed and randomized command sequences checked against a timeline model of the ramp rules.
module tb_motor_cmd_sequencer;
   import motor_pkg::*;

   localparam int TD    = 4;
   localparam int STK   = 2;
   localparam int BTK   = 3;
   localparam int S_CYC = STK * TD;
   localparam int B_CYC = BTK * TD;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       estop = 1'b0;
   logic [2:0] psw, state_o;
   logic       busy;
   int         errors = 0;
   int         checks = 0;
   logic       m_dir;
   logic [1:0] m_spd;

   motor_cmd_sequencer_if bus ();

   motor_cmd_sequencer #(.TICK_DIV(TD), .STEP_TICKS(STK), .BRAKE_TICKS(BTK)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cmd     (bus),
      .estop   (estop),
      .psw     (psw),
      .busy    (busy),
      .state_o (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: list of (edge offset, psw) changes derived from the ramp/brake rules.
   task automatic run_cmd(input logic d, input logic [1:0] s);
      int         ev_t[$];
      logic [2:0] ev_p[$];
      int         t, brk_a, brk_b, t_end;
      logic [2:0] exp_p;
      t = 0; brk_a = -1; brk_b = -1;
      ev_t.push_back(0); ev_p.push_back({m_dir, m_spd});
      if (d != m_dir && m_spd != SPD_OFF) begin
         while (m_spd != SPD_OFF) begin
            m_spd--; t += S_CYC;
            ev_t.push_back(t); ev_p.push_back({m_dir, m_spd});
         end
         brk_a = t; t += B_CYC; brk_b = t;
      end
      m_dir = d;
      ev_t.push_back(t); ev_p.push_back({m_dir, m_spd});
      while (m_spd != s) begin
         if (m_spd < s) m_spd++; else m_spd--;
         t += S_CYC;
         ev_t.push_back(t); ev_p.push_back({m_dir, m_spd});
      end
      t_end = t;

      @(negedge clk);
      chk("ready_before_cmd", 8'(bus.cmd_ready), 8'd1);
      bus.cmd_valid = 1'b1; bus.cmd_dir = d; bus.cmd_speed = s;
      @(posedge clk);
      for (int k = 0; k <= t_end + 2; k++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         exp_p = ev_p[0];
         foreach (ev_t[i]) if (ev_t[i] <= k) exp_p = ev_p[i];
         chk("psw", 8'(psw), 8'(exp_p));
         chk("busy", 8'(busy), 8'(k < t_end));
         chk("in_brake", 8'(state_o == ST_BRAKE), 8'(k >= brk_a && k < brk_b));
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_speed = SPD_OFF;
      m_dir = 1'b0; m_spd = SPD_OFF;

      // Reset values and idle behaviour
      #12;
      chk("rst_psw", 8'(psw), 8'h0);
      chk("rst_ready", 8'(bus.cmd_ready), 8'd1);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_state", 8'(state_o), 8'(ST_HOLD));
      @(negedge clk) rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("idle_psw", 8'(psw), 8'h0);
         chk("idle_ready", 8'(bus.cmd_ready), 8'd1);
         chk("idle_busy", 8'(busy), 8'd0);
      end

      run_cmd(1'b0, SPD_75);   // ramp up 001@8 010@16 011@24
      run_cmd(1'b0, SPD_50);
      run_cmd(1'b1, SPD_25);   // reversal through brake
      run_cmd(1'b0, SPD_OFF);  // reversal ending at OFF
      run_cmd(1'b1, SPD_50);   // reversal from OFF, no brake
      run_cmd(1'b1, SPD_OFF);

      // Emergency stop mid-ramp with a competing request held
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b0; bus.cmd_speed = SPD_75;
      @(posedge clk);
      @(negedge clk) bus.cmd_valid = 1'b0;
      repeat (16) @(negedge clk);
      chk("pre_estop_psw", 8'(psw), 8'(3'b010));
      estop = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b1; bus.cmd_speed = SPD_25;
      #1 chk("estop_ready_comb", 8'(bus.cmd_ready), 8'd0);
      repeat (5) begin
         @(negedge clk);
         chk("estop_psw", 8'(psw), 8'h0);
         chk("estop_state", 8'(state_o), 8'(ST_ESTOP));
         chk("estop_ready", 8'(bus.cmd_ready), 8'd0);
      end
      estop = 1'b0;
      #1 chk("estop_exit_ready", 8'(bus.cmd_ready), 8'd0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("post_estop_state", 8'(state_o), 8'(ST_HOLD));
      chk("post_estop_psw", 8'(psw), 8'h0);
      chk("post_estop_busy", 8'(busy), 8'd0);
      m_dir = 1'b0; m_spd = SPD_OFF;

      // Asynchronous reset mid-ramp
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b0; bus.cmd_speed = SPD_50;
      @(posedge clk);
      @(negedge clk) bus.cmd_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("pre_rst_psw", 8'(psw), 8'(3'b001));
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_psw", 8'(psw), 8'h0);
      chk("async_rst_state", 8'(state_o), 8'(ST_HOLD));
      chk("async_rst_busy", 8'(busy), 8'd0);
      @(negedge clk) rst_n = 1'b1;
      m_dir = 1'b0; m_spd = SPD_OFF;
      chk("post_rst_ready", 8'(bus.cmd_ready), 8'd1);
      run_cmd(1'b0, SPD_OFF);  // same-value no-op

      repeat (15) run_cmd(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
